// File: rtl/spi_adc_sequencer.sv
// -----------------------------------------------------------------------------
// spi_adc_sequencer
//
// Runs one averaging sweep over the enabled ADC channels every time the
// sample-rate generator pulses sample_tick. For each enabled channel, in
// ascending index order, it requests 2**AVG_LOG2 back-to-back conversions from
// the SPI engine. It sums the returned codes and emits one truncated average
// tagged with the channel number.
//
// If a conversion never returns within TIMEOUT_CYC cycles, the channel is
// abandoned without a result. The sticky timeout_err flag is then set and the
// sweep continues with the next enabled channel.
//
// Ports
//   clk            system clock, shared with the SPI engine
//   reset          asynchronous, active-high reset
//   sample_tick    one-cycle pulse: start a sweep (dropped while busy)
//   ch_enable      per-channel enable mask, captured at sweep start
//   clear_err      one-cycle pulse: clear overrun / timeout_err
//   spi_start      one-cycle conversion request to the SPI engine
//   spi_channel    channel select, stable from spi_start to spi_data_valid
//   spi_data_valid one-cycle pulse: spi_data holds a finished conversion
//   spi_data       12-bit conversion code
//   result_valid   one-cycle pulse: result_ch / result_data are new
//   result_ch      channel of the most recent result (held)
//   result_data    averaged code of the most recent result (held)
//   busy           sweep in progress
//   overrun        sticky: a sample_tick arrived while busy
//   timeout_err    sticky: a conversion timed out
// -----------------------------------------------------------------------------
module spi_adc_sequencer #(
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 1023,
  parameter int NCH         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic [NCH-1:0]   ch_enable,
  input  logic             clear_err,
  output logic             spi_start,
  output logic [1:0]       spi_channel,
  input  logic             spi_data_valid,
  input  logic [11:0]      spi_data,
  output logic             result_valid,
  output logic [1:0]       result_ch,
  output logic [11:0]      result_data,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int DATA_W = 12;
  localparam int CH_W   = 2;
  // The sum of 2**AVG_LOG2 codes needs AVG_LOG2 extra bits and can never wrap.
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  // The sample counter must hold the full count 2**AVG_LOG2.
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] N_AVG   = CNT_W'(2 ** AVG_LOG2);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT,
    S_NEXT
  } state_t;

  state_t            state;
  logic [NCH-1:0]    mask;
  logic [CH_W-1:0]   ch;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   to_cnt;

  logic [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CH_W:0]     nxt;

  // Lowest set bit of the enable mask (caller guarantees mask != 0).
  function automatic logic [CH_W-1:0] first_ch(input logic [NCH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // Next set bit strictly above cur, returned as {found, index}.
  function automatic logic [CH_W:0] next_ch(input logic [NCH-1:0] m,
                                            input logic [CH_W-1:0] cur);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  // Truncating average: dropping the low AVG_LOG2 bits divides by the count.
  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] s);
    return s[ACC_W-1:AVG_LOG2];
  endfunction

  assign acc_sum = acc + ACC_W'(spi_data);
  assign cnt_inc = cnt + CNT_W'(1);
  assign nxt     = next_ch(mask, ch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      mask         <= '0;
      ch           <= '0;
      acc          <= '0;
      cnt          <= '0;
      to_cnt       <= '0;
      spi_start    <= 1'b0;
      spi_channel  <= '0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      spi_start    <= 1'b0;
      result_valid <= 1'b0;

      // Clear first, so that a set event in the same cycle overrides it.
      if (clear_err) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      // busy is still high in the NEXT cycle, so a tick there is dropped too.
      if (sample_tick && busy) overrun <= 1'b1;

      case (state)
        // ---- idle: wait for a tick with at least one channel enabled ----
        S_IDLE: begin
          if (sample_tick && (|ch_enable)) begin
            mask  <= ch_enable;
            ch    <= first_ch(ch_enable);
            busy  <= 1'b1;
            state <= S_ISSUE;
          end
        end

        // ---- issue: request one conversion on the current channel ----
        S_ISSUE: begin
          spi_start   <= 1'b1;
          spi_channel <= ch;
          to_cnt      <= '0;
          state       <= S_WAIT;
        end

        // ---- wait: accumulate the returned code or give up on timeout ----
        S_WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          // Valid data is checked before the timeout, so it wins a tie.
          if (spi_data_valid) begin
            acc <= acc_sum;
            cnt <= cnt_inc;
            if (cnt_inc == N_AVG) begin
              // The result is registered here so that result_valid shows up
              // during OUTPUT, one cycle after the last conversion.
              result_data  <= avg_trunc(acc_sum);
              result_ch    <= ch;
              result_valid <= 1'b1;
              state        <= S_OUTPUT;
            end else begin
              state <= S_ISSUE;
            end
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_NEXT;
          end
        end

        // ---- output: result_valid is high for this single cycle ----
        S_OUTPUT: begin
          state <= S_NEXT;
        end

        // ---- next: drop the partial sum and move to the next channel ----
        S_NEXT: begin
          acc <= '0;
          cnt <= '0;
          if (nxt[CH_W]) begin
            ch    <= nxt[CH_W-1:0];
            state <= S_ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_sequencer.sv
`timescale 1ns/1ps
module tb_spi_adc_sequencer;

  logic        clk;
  logic        reset;
  logic        sample_tick;
  logic [3:0]  ch_enable;
  logic        clear_err;
  logic        spi_start;
  logic [1:0]  spi_channel;
  logic        spi_data_valid;
  logic [11:0] spi_data;
  logic        result_valid;
  logic [1:0]  result_ch;
  logic [11:0] result_data;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  logic [20:0] out_vec;
  assign out_vec = {spi_start, spi_channel, result_valid, result_ch,
                    result_data, busy, overrun, timeout_err};

  int n_checks = 0;
  int n_errors = 0;

  // SPI engine model controls
  int eng_tab [0:255];
  int eng_idx = 0;
  int eng_delay = 2;
  bit eng_respond = 1'b1;
  int start_cnt = 0;
  int start_ch_log [0:255];

  // result monitor
  int res_cnt = 0;
  int res_ch_log [0:63];
  int res_data_log [0:63];
  int busy_viol = 0;

  int base_s, base_r, idx, snap_s, snap_r;

  spi_adc_sequencer #(
    .AVG_LOG2    (2),
    .TIMEOUT_CYC (1023),
    .NCH         (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_tick    (sample_tick),
    .ch_enable      (ch_enable),
    .clear_err      (clear_err),
    .spi_start      (spi_start),
    .spi_channel    (spi_channel),
    .spi_data_valid (spi_data_valid),
    .spi_data       (spi_data),
    .result_valid   (result_valid),
    .result_ch      (result_ch),
    .result_data    (result_data),
    .busy           (busy),
    .overrun        (overrun),
    .timeout_err    (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SPI engine: answers each spi_start eng_delay cycles later with the next table entry
  initial begin
    spi_data_valid = 1'b0;
    spi_data       = '0;
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        start_ch_log[start_cnt] = int'(spi_channel);
        start_cnt = start_cnt + 1;
        if (eng_respond) begin
          repeat (eng_delay) @(negedge clk);
          spi_data       = 12'(eng_tab[eng_idx]);
          eng_idx        = eng_idx + 1;
          spi_data_valid = 1'b1;
          @(negedge clk);
          spi_data_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      res_ch_log[res_cnt]   <= int'(result_ch);
      res_data_log[res_cnt] <= int'(result_data);
      res_cnt               <= res_cnt + 1;
    end
    if ((spi_start === 1'b1 || result_valid === 1'b1) && busy !== 1'b1)
      busy_viol <= busy_viol + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick(input logic [3:0] en);
    @(negedge clk);
    ch_enable   = en;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    check_val(tag, int'(busy), 0);
  endtask

  task automatic wait_start(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1) break;
    end
    check_val(tag, int'(spi_start), 1);
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (start_cnt >= target) break;
    end
    check_val(tag, (start_cnt >= target) ? 1 : 0, 1);
  endtask

  initial begin
    reset       = 1'b1;
    sample_tick = 1'b0;
    ch_enable   = '0;
    clear_err   = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_outputs", int'(out_vec), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // T1: two channels, averaging and ordering
    base_s = start_cnt; base_r = res_cnt; idx = eng_idx;
    eng_tab[idx+0] = 100; eng_tab[idx+1] = 101;
    eng_tab[idx+2] = 102; eng_tab[idx+3] = 103;
    for (int k = 4; k < 8; k++) eng_tab[idx+k] = 4095;
    eng_delay = 2; eng_respond = 1'b1;
    pulse_tick(4'b0101);
    check_val("t1_busy_on", int'(busy), 1);
    wait_idle("t1_idle", 300);
    @(negedge clk);
    check_val("t1_starts", start_cnt - base_s, 8);
    check_val("t1_first_ch", start_ch_log[base_s], 0);
    check_val("t1_fifth_ch", start_ch_log[base_s+4], 2);
    check_val("t1_nres", res_cnt - base_r, 2);
    check_val("t1_res0_ch", res_ch_log[base_r], 0);
    check_val("t1_res0_data", res_data_log[base_r], 101);
    check_val("t1_res1_ch", res_ch_log[base_r+1], 2);
    check_val("t1_res1_data", res_data_log[base_r+1], 4095);
    check_val("t1_hold_data", int'(result_data), 4095);
    check_val("t1_hold_ch", int'(result_ch), 2);
    check_val("t1_flags", int'({overrun, timeout_err}), 0);

    // T3: second tick 5 cycles later (with a changed mask) is dropped
    base_s = start_cnt; base_r = res_cnt; idx = eng_idx;
    eng_tab[idx+0] = 10; eng_tab[idx+1] = 20; eng_tab[idx+2] = 30; eng_tab[idx+3] = 40;
    eng_tab[idx+4] = 1;  eng_tab[idx+5] = 2;  eng_tab[idx+6] = 3;  eng_tab[idx+7] = 5;
    pulse_tick(4'b0011);
    repeat (3) @(negedge clk);
    check_val("t3_overrun_before", int'(overrun), 0);
    pulse_tick(4'b1111);
    check_val("t3_overrun_set", int'(overrun), 1);
    wait_idle("t3_idle", 300);
    @(negedge clk);
    check_val("t3_starts", start_cnt - base_s, 8);
    check_val("t3_nres", res_cnt - base_r, 2);
    check_val("t3_res0", res_ch_log[base_r]*10000 + res_data_log[base_r], 25);
    check_val("t3_res1", res_ch_log[base_r+1]*10000 + res_data_log[base_r+1], 10002);
    check_val("t3_overrun_sticky", int'(overrun), 1);
    pulse_clear();
    check_val("t3_overrun_clr", int'(overrun), 0);

    // T4: empty mask ignored, then only ch3
    base_s = start_cnt; base_r = res_cnt;
    pulse_tick(4'b0000);
    check_val("t4_busy_empty", int'(busy), 0);
    repeat (10) @(negedge clk);
    check_val("t4_no_start", start_cnt - base_s, 0);
    check_val("t4_no_flags", int'({busy, overrun, timeout_err}), 0);
    idx = eng_idx;
    eng_tab[idx+0] = 7; eng_tab[idx+1] = 7; eng_tab[idx+2] = 7; eng_tab[idx+3] = 9;
    pulse_tick(4'b1000);
    wait_idle("t4_idle", 200);
    @(negedge clk);
    check_val("t4_starts", start_cnt - base_s, 4);
    check_val("t4_start_ch", start_ch_log[base_s], 3);
    check_val("t4_nres", res_cnt - base_r, 1);
    check_val("t4_res", res_ch_log[base_r]*10000 + res_data_log[base_r], 30007);
    check_val("t4_spi_ch_hold", int'(spi_channel), 3);

    // T2: engine silent on ch1 -> timeout after exactly 1023 cycles
    base_r = res_cnt;
    eng_respond = 1'b0;
    pulse_tick(4'b0010);
    wait_start("t2_start", 20);
    check_val("t2_spi_ch", int'(spi_channel), 1);
    repeat (1022) @(negedge clk);
    check_val("t2_to_early", int'(timeout_err), 0);
    @(negedge clk);
    check_val("t2_to_at", int'(timeout_err), 1);
    wait_idle("t2_idle", 10);
    check_val("t2_nres", res_cnt - base_r, 0);
    pulse_clear();
    check_val("t2_to_clr", int'(timeout_err), 0);

    // T6a: clear_err in the same cycle as the timeout -> set wins
    pulse_tick(4'b0001);
    wait_start("t6a_start", 20);
    repeat (1022) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check_val("t6a_set_wins", int'(timeout_err), 1);
    wait_idle("t6a_idle", 10);
    pulse_clear();
    check_val("t6a_clr", int'(timeout_err), 0);

    // T6b: data arriving on the timeout cycle is kept
    base_r = res_cnt; idx = eng_idx;
    eng_tab[idx+0] = 40; eng_tab[idx+1] = 44; eng_tab[idx+2] = 48; eng_tab[idx+3] = 52;
    eng_delay = 1022; eng_respond = 1'b1;
    pulse_tick(4'b0001);
    wait_start("t6b_start", 20);
    repeat (1023) @(negedge clk);
    check_val("t6b_no_to_first", int'(timeout_err), 0);
    wait_idle("t6b_idle", 5000);
    @(negedge clk);
    check_val("t6b_nres", res_cnt - base_r, 1);
    check_val("t6b_res", res_ch_log[base_r]*10000 + res_data_log[base_r], 46);
    check_val("t6b_no_to", int'(timeout_err), 0);
    eng_delay = 5;

    // T5: reset during WAIT on ch1, then a clean sweep
    base_s = start_cnt; idx = eng_idx;
    for (int k = 0; k < 16; k++) eng_tab[idx+k] = 50;
    pulse_tick(4'b1111);
    wait_starts("t5_reach_ch1", base_s + 5, 200);
    @(negedge clk);
    check_val("t5_in_ch1", start_ch_log[base_s+4]*10 + int'(spi_channel), 11);
    check_val("t5_busy_pre", int'(busy), 1);
    snap_s = start_cnt; snap_r = res_cnt;
    reset = 1'b1;
    #1;
    check_val("t5_reset_outputs", int'(out_vec), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check_val("t5_no_start", start_cnt - snap_s, 0);
    check_val("t5_no_result", res_cnt - snap_r, 0);
    check_val("t5_idle_after", int'(busy), 0);
    base_s = start_cnt; base_r = res_cnt; idx = eng_idx;
    for (int k = 0; k < 4; k++) eng_tab[idx+k] = 8;
    eng_tab[idx+4] = 16; eng_tab[idx+5] = 16; eng_tab[idx+6] = 16; eng_tab[idx+7] = 20;
    eng_delay = 2;
    pulse_tick(4'b0011);
    wait_idle("t5_idle", 300);
    @(negedge clk);
    check_val("t5_first_ch", start_ch_log[base_s], 0);
    check_val("t5_starts", start_cnt - base_s, 8);
    check_val("t5_nres", res_cnt - base_r, 2);
    check_val("t5_res0", res_ch_log[base_r]*10000 + res_data_log[base_r], 8);
    check_val("t5_res1", res_ch_log[base_r+1]*10000 + res_data_log[base_r+1], 10017);

    check_val("busy_covers_activity", busy_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_adc_sequencer.md
Name: spi_adc_sequencer

Overview:
Sequences the SPI ADC engine across up to four ADC input channels. On each periodic sample tick it performs one sweep: for every enabled channel, in ascending index order, it runs 2**AVG_LOG2 back-to-back conversions, accumulates them and emits one averaged 12-bit result per channel. It sits between the sample-rate generator and the SPI state machine, and feeds the LED/7-segment display logic with channel-tagged results.

Parameters:
AVG_LOG2, 2, log2 of conversions averaged per channel (legal 0..4)
TIMEOUT_CYC, 1023, max clk cycles to wait for spi_data_valid after spi_start before aborting
NCH, 4, number of channels (fixed at 4; channel index is 2 bits)

Ports:
clk  input  1  system clock (same domain as SPI engine)
reset  input  1  asynchronous, active-high reset
sample_tick  input  1  one-cycle pulse that starts a sweep
ch_enable  input  4  per-channel enable, sampled at sweep start
clear_err  input  1  one-cycle pulse that clears the sticky error flags
spi_start  output  1  one-cycle request to the SPI engine
spi_channel  output  2  channel select to the SPI engine, held stable from spi_start through spi_data_valid
spi_data_valid  input  1  one-cycle pulse: spi_data holds a completed conversion
spi_data  input  12  conversion result
result_valid  output  1  one-cycle pulse: result_ch/result_data are valid
result_ch  output  2  channel of the current result
result_data  output  12  averaged result
busy  output  1  high from sweep accept until the last result/abort of the sweep
overrun  output  1  sticky: a sample_tick arrived while busy
timeout_err  output  1  sticky: a conversion timed out

Behaviour:
- Reset (async, active-high): state IDLE; every output 0; accumulator, sample counter, timeout counter and latched enable mask all 0.
- State IDLE: on sample_tick with ch_enable != 0 -> latch mask = ch_enable, ch = lowest set bit, busy=1, go to ISSUE. A tick with ch_enable == 0 is ignored and leaves no flags set.
- State ISSUE: drive spi_start=1 for exactly one cycle with spi_channel=ch, clear the timeout counter, go to WAIT.
- State WAIT: timeout counter increments every cycle.
  - On spi_data_valid: acc += spi_data (acc width 12+AVG_LOG2, no overflow possible) and the sample count increments. If count == 2**AVG_LOG2 -> go to OUTPUT; else go to ISSUE (the next spi_start follows spi_data_valid by exactly 2 cycles).
  - If the counter reaches TIMEOUT_CYC with no valid: set timeout_err, discard acc, produce no result for ch, go to NEXT.
  - spi_data_valid and timeout in the same cycle: the data wins and no timeout is recorded.
- State OUTPUT: result_data = acc >> AVG_LOG2 (truncating), result_ch = ch, result_valid pulses for 1 cycle in this state; then go to NEXT. Latency from the last spi_data_valid to result_valid is 1 cycle.
- State NEXT: clear acc and count. If a higher set bit remains in mask -> ch = next set bit, go to ISSUE. Otherwise busy=0, go to IDLE. busy falls in the cycle after NEXT.
- spi_data_valid while in IDLE, ISSUE or NEXT is ignored.
- ch_enable changes mid-sweep have no effect until the next sweep.
- sample_tick while busy=1: the tick is dropped and overrun is set. A tick in the same cycle that busy falls is also dropped.
- clear_err clears overrun and timeout_err. If a set event occurs in the same cycle, the set wins.
- spi_channel holds its last value in IDLE.
- result_data/result_ch hold their last value between pulses.
- AVG_LOG2=0: each conversion is output directly; acc width is 12.
- Reset asserted mid-sweep: immediate return to IDLE with all outputs 0. There is no pending spi_start and no result.

Test Plan:
1. ch_enable=4'b0101, AVG_LOG2=2, engine returns 100,101,102,103 on ch0 and 4095 four times on ch2, tick -> result (ch0, 101) then (ch2, 4095); exactly 8 spi_start pulses; busy high throughout, then low.
2. Engine never asserts spi_data_valid on ch1 (ch_enable=4'b0010) -> timeout_err=1 exactly 1023 cycles after spi_start; no result_valid; busy drops; clear_err -> timeout_err=0.
3. Second sample_tick 5 cycles after the first, during a sweep -> overrun=1; the sweep completes unaffected; exactly one result per enabled channel.
4. ch_enable=4'b0000 with tick -> no spi_start, busy stays 0, no flags; then ch_enable=4'b1000 -> only ch3 is sampled and spi_channel=3.
5. Assert reset during WAIT on ch1 of a 4-channel sweep -> all outputs 0 immediately; after release, a tick starts a fresh sweep at ch0 with a clean average (inputs 8,8,8,8 -> 8).
6. clear_err in the same cycle as a timeout -> timeout_err remains 1; spi_data_valid in the same cycle the timeout is reached -> the data is accumulated and timeout_err stays 0.
